// File: rtl/mm_sram_ctrl.sv
// Memory-mapped to synchronous SRAM bridge with fixed read latency and write waits.
// Optional MM_SRAM_CTRL_RDHOLD_EN: s_rdat holds the last read data continuously.
module mm_sram_ctrl #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int RLAT    = 2,
  parameter int WSTATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_wdat,
  output logic              ram_re,
  input  logic [DWIDTH-1:0] ram_rdat
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam logic [3:0] L_RLAT = 4'(RLAT);
  localparam logic [3:0] L_WS   = 4'(WSTATES);

  if (RLAT < 1 || RLAT > 15) begin : g_bad_rlat
    $error("mm_sram_ctrl: RLAT out of range 1..15");
  end
  if (WSTATES < 0 || WSTATES > 15) begin : g_bad_ws
    $error("mm_sram_ctrl: WSTATES out of range 0..15");
  end

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_we;
  logic                r_re;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdat;
  logic [DWIDTH-1:0]   r_rdat;
  logic                r_rd_last;
  logic                w_busy;
  logic                w_start_wr;
  logic                w_start_rd;
  logic                w_cap;

  // Write wins when both requests arrive together.
  assign w_start_wr = (r_state == IDLE) && s_wreq;
  assign w_start_rd = (r_state == IDLE) && !s_wreq && s_rreq;
  assign w_cap      = (r_state == READ) && (r_cnt == 4'd0);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_busy    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = s_wreq | s_rreq;
        if (s_wreq) begin
          w_next    = WRITE;
          w_cnt_nxt = L_WS;
        end else if (s_rreq) begin
          w_next    = READ;
          w_cnt_nxt = L_RLAT;
        end
      end
      WRITE, READ: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_rdat    <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_we <= w_start_wr;
      r_re <= w_start_rd;
      if (w_start_wr || w_start_rd) begin
        r_addr    <= s_addr;
        r_rd_last <= w_start_rd;
      end
      if (w_start_wr) begin
        r_wdat <= s_wdat;
      end
      if (w_cap) begin
        r_rdat <= ram_rdat;
      end
    end
  end

  assign s_busy   = w_busy;
  assign ram_addr = r_addr;
  assign ram_we   = r_we;
  assign ram_wdat = r_wdat;
  assign ram_re   = r_re;

`ifdef MM_SRAM_CTRL_RDHOLD_EN
  assign s_rdat = r_rdat;
`else
  assign s_rdat = (r_state == DONE && r_rd_last) ? r_rdat : '0;
`endif

endmodule

// File: tb/tb_mm_sram_ctrl.sv
// Directed bench for mm_sram_ctrl: three configurations sharing one stimulus bus.
// Instance 0: RLAT=2/WSTATES=0, instance 1: WSTATES=3, instance 2: RLAT=4.
module tb_mm_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = '0;
  logic       wr = 1'b0;
  logic [7:0] wdat = '0;
  logic       rd = 1'b0;

  logic [7:0] rdat_o  [3];
  logic       busy_o  [3];
  logic [7:0] raddr_o [3];
  logic       we_o    [3];
  logic [7:0] wdat_o  [3];
  logic       re_o    [3];
  logic [7:0] rdin    [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 2) ? 4 : 2;
    localparam int WS = (g == 1) ? 3 : 0;
    logic [7:0] mem [256];
    logic [3:0] vld;
    logic [7:0] dly [4];

    mm_sram_ctrl #(
      .AWIDTH(8), .DWIDTH(8), .RLAT(RL), .WSTATES(WS)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .s_addr   (addr),
      .s_wreq   (wr),
      .s_wdat   (wdat),
      .s_rreq   (rd),
      .s_rdat   (rdat_o[g]),
      .s_busy   (busy_o[g]),
      .ram_addr (raddr_o[g]),
      .ram_we   (we_o[g]),
      .ram_wdat (wdat_o[g]),
      .ram_re   (re_o[g]),
      .ram_rdat (rdin[g])
    );

    // SRAM model: data valid only in cycle t+RL, 0xEE otherwise.
    always @(posedge clk) begin
      if (we_o[g]) mem[raddr_o[g]] <= wdat_o[g];
      if (!rst_n) vld <= '0;
      else vld <= {vld[2:0], re_o[g]};
      dly[0] <= raddr_o[g];
      for (int k = 1; k < 4; k++) dly[k] <= dly[k-1];
    end
    assign rdin[g] = vld[RL-1] ? mem[dly[RL-1]] : 8'hEE;
  end

  typedef struct {
    logic       rst_n;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdat;
    logic       busy;
    logic       we;
    logic       re;
    logic [7:0] raddr;
    logic [7:0] rwdat;
    logic [7:0] rdp;
    logic [7:0] rdh;
  } vec_t;

  vec_t vq[$];

  function automatic void v(
    input logic r, input logic w, input logic d,
    input logic [7:0] a, input logic [7:0] wd,
    input logic b, input logic e, input logic re,
    input logic [7:0] ra, input logic [7:0] rw,
    input logic [7:0] p, input logic [7:0] h);
    vec_t t;
    t = '{r, w, d, a, wd, b, e, re, ra, rw, p, h};
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] p,
                                        input logic [7:0] h);
`ifdef MM_SRAM_CTRL_RDHOLD_EN
    return h;
`else
    return p;
`endif
  endfunction

  int we_cnt;
  logic [7:0] expv;

  initial begin
    // reset, write 0x12=A5, read it back
    v(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00,8'h00,8'h00);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00,8'h00,8'h00);
    v(1,1,0,8'h12,8'hA5, 1,0,0,8'h00,8'h00,8'h00,8'h00);
    v(1,1,0,8'h12,8'hA5, 1,1,0,8'h12,8'hA5,8'h00,8'h00);
    v(1,1,0,8'h12,8'hA5, 0,0,0,8'h12,8'hA5,8'h00,8'h00);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h12,8'hA5,8'h00,8'h00);
    v(1,0,1,8'h12,8'h00, 1,0,0,8'h12,8'hA5,8'h00,8'h00);
    v(1,0,1,8'h12,8'h00, 1,0,1,8'h12,8'hA5,8'h00,8'h00);
    v(1,0,1,8'h12,8'h00, 1,0,0,8'h12,8'hA5,8'h00,8'h00);
    v(1,0,1,8'h12,8'h00, 1,0,0,8'h12,8'hA5,8'h00,8'h00);
    v(1,0,1,8'h12,8'h00, 0,0,0,8'h12,8'hA5,8'hA5,8'hA5);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h12,8'hA5,8'h00,8'hA5);
    // simultaneous write and read: write only
    v(1,1,1,8'h20,8'h3C, 1,0,0,8'h12,8'hA5,8'h00,8'hA5);
    v(1,1,1,8'h20,8'h3C, 1,1,0,8'h20,8'h3C,8'h00,8'hA5);
    v(1,1,1,8'h20,8'h3C, 0,0,0,8'h20,8'h3C,8'h00,8'hA5);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h20,8'h3C,8'h00,8'hA5);
    // write 0x33=5A, read it, idle 3 cycles
    v(1,1,0,8'h33,8'h5A, 1,0,0,8'h20,8'h3C,8'h00,8'hA5);
    v(1,1,0,8'h33,8'h5A, 1,1,0,8'h33,8'h5A,8'h00,8'hA5);
    v(1,1,0,8'h33,8'h5A, 0,0,0,8'h33,8'h5A,8'h00,8'hA5);
    v(1,0,1,8'h33,8'h00, 1,0,0,8'h33,8'h5A,8'h00,8'hA5);
    v(1,0,1,8'h33,8'h00, 1,0,1,8'h33,8'h5A,8'h00,8'hA5);
    v(1,0,1,8'h33,8'h00, 1,0,0,8'h33,8'h5A,8'h00,8'hA5);
    v(1,0,1,8'h33,8'h00, 1,0,0,8'h33,8'h5A,8'h00,8'hA5);
    v(1,0,1,8'h33,8'h00, 0,0,0,8'h33,8'h5A,8'h5A,8'h5A);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h33,8'h5A,8'h00,8'h5A);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h33,8'h5A,8'h00,8'h5A);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h33,8'h5A,8'h00,8'h5A);
    // read request dropped mid-READ still completes
    v(1,0,1,8'h12,8'h00, 1,0,0,8'h33,8'h5A,8'h00,8'h5A);
    v(1,0,0,8'h00,8'h00, 1,0,1,8'h12,8'h5A,8'h00,8'h5A);
    v(1,0,0,8'h00,8'h00, 1,0,0,8'h12,8'h5A,8'h00,8'h5A);
    v(1,0,0,8'h00,8'h00, 1,0,0,8'h12,8'h5A,8'h00,8'h5A);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h12,8'h5A,8'hA5,8'hA5);
    v(1,0,0,8'h00,8'h00, 0,0,0,8'h12,8'h5A,8'h00,8'hA5);

    for (int i = 0; i < vq.size(); i++) begin
      rst_n = vq[i].rst_n;
      wr    = vq[i].wr;
      rd    = vq[i].rd;
      addr  = vq[i].addr;
      wdat  = vq[i].wdat;
      @(negedge clk);
      chk($sformatf("row%0d busy", i), {7'd0, busy_o[0]}, {7'd0, vq[i].busy});
      chk($sformatf("row%0d ram_we", i), {7'd0, we_o[0]}, {7'd0, vq[i].we});
      chk($sformatf("row%0d ram_re", i), {7'd0, re_o[0]}, {7'd0, vq[i].re});
      chk($sformatf("row%0d ram_addr", i), raddr_o[0], vq[i].raddr);
      chk($sformatf("row%0d ram_wdat", i), wdat_o[0], vq[i].rwdat);
      chk($sformatf("row%0d s_rdat", i), rdat_o[0],
          exp_rd(vq[i].rdp, vq[i].rdh));
      cyc();
    end

    // WSTATES=3 single write on instance 1
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    wr = 1'b1; addr = 8'h44; wdat = 8'h99;
    we_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) wr = 1'b0;
      @(negedge clk);
      if (c < 6)
        chk($sformatf("ws3 busy c%0d", c), {7'd0, busy_o[1]},
            (c < 5) ? 8'd1 : 8'd0);
      if (c == 1)
        chk("ws3 we c1", {7'd0, we_o[1]}, 8'd1);
      if (we_o[1]) we_cnt++;
      cyc();
    end
    chk("ws3 we pulses", 8'(we_cnt), 8'd1);

    // RLAT=4 read aborted by reset in cycle 2, then fresh write/read
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    rd = 1'b1; addr = 8'h12;
    @(negedge clk);
    chk("rl4 busy c0", {7'd0, busy_o[2]}, 8'd1);
    cyc();
    @(negedge clk);
    chk("rl4 re c1", {7'd0, re_o[2]}, 8'd1);
    cyc();
    @(negedge clk);
    chk("rl4 addr c2", raddr_o[2], 8'h12);
    rst_n = 1'b0; rd = 1'b0;
    #1;
    chk("rl4 rst busy", {7'd0, busy_o[2]}, 8'd0);
    chk("rl4 rst addr", raddr_o[2], 8'h00);
    chk("rl4 rst re", {7'd0, re_o[2]}, 8'd0);
    chk("rl4 rst rdat", rdat_o[2], 8'h00);
    cyc();
    @(negedge clk);
    chk("rl4 in rst busy", {7'd0, busy_o[2]}, 8'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    wr = 1'b1; addr = 8'h01; wdat = 8'h77;
    @(negedge clk);
    chk("rl4 wr busy c0", {7'd0, busy_o[2]}, 8'd1);
    cyc();
    @(negedge clk);
    chk("rl4 wr we c1", {7'd0, we_o[2]}, 8'd1);
    chk("rl4 wr addr c1", raddr_o[2], 8'h01);
    chk("rl4 wr wdat c1", wdat_o[2], 8'h77);
    cyc();
    @(negedge clk);
    chk("rl4 wr busy c2", {7'd0, busy_o[2]}, 8'd0);
    cyc();
    wr = 1'b0;
    cyc();
    rd = 1'b1; addr = 8'h01;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("rl4 rd busy c%0d", c), {7'd0, busy_o[2]},
          (c < 6) ? 8'd1 : 8'd0);
      if (c == 1)
        chk("rl4 rd re c1", {7'd0, re_o[2]}, 8'd1);
      if (c == 6)
        chk("rl4 rd rdat c6", rdat_o[2], 8'h77);
      cyc();
    end
    rd = 1'b0;
    cyc();
    @(negedge clk);
    expv = exp_rd(8'h00, 8'h77);
    chk("rl4 rdat after", rdat_o[2], expv);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
